// File: rtl/jam_pkg.sv
// jam_pkg: shared types and constants for the jam-mode sequencer.
//   jam_state_e   FSM states (IDLE, START, SERVE, ROTATE)
//   lane_idx_t    2-bit lane index
//   DEF_DEBOUNCE_CYCLES / DEF_GREEN_CYCLES  default timing constants
//   lane_encode   lowest-index priority encode of a 4-bit grant vector
//   is_onehot     exactly-one-bit-set test for a 4-bit grant vector
package jam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_SERVE  = 2'd2,
    ST_ROTATE = 2'd3
  } jam_state_e;

  typedef logic [1:0] lane_idx_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_GREEN_CYCLES    = 20;

  function automatic lane_idx_t lane_encode(input logic [3:0] v);
    lane_idx_t idx;
    idx = '0;
    // Scan high to low so the lowest set bit wins.
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = lane_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/jam_ctrl_unit_if.sv
// jam_ctrl_unit_if: bundles the lane-sensor inputs, arbiter grant feedback
// and the sequencer's control outputs.
//   master: environment side (drives traffic_jam_*, allow_*_jam)
//   slave : jam_ctrl_unit side (drives jam_opp_en, jam_start, jam_rotation,
//           serve_lane, rotation_cnt, ack_err, state_dbg)
//
// Signalling: there is no valid/ready pair. jam_opp_en is a level enable;
// jam_start and jam_rotation are single-cycle command pulses, never high
// together, which the arbiter acts on at the following rising edge; the
// arbiter answers with its allow_*_jam one-hot, which the sequencer only
// observes.
interface jam_ctrl_unit_if;
  import jam_pkg::*;

  logic       traffic_jam_0, traffic_jam_1, traffic_jam_2, traffic_jam_3;
  logic       allow_0_jam, allow_1_jam, allow_2_jam, allow_3_jam;
  logic       jam_opp_en;
  logic       jam_start;
  logic       jam_rotation;
  lane_idx_t  serve_lane;
  logic [7:0] rotation_cnt;
  logic       ack_err;
  jam_state_e state_dbg;

  modport master (
    output traffic_jam_0, traffic_jam_1, traffic_jam_2, traffic_jam_3,
    output allow_0_jam, allow_1_jam, allow_2_jam, allow_3_jam,
    input  jam_opp_en, jam_start, jam_rotation, serve_lane, rotation_cnt,
    input  ack_err, state_dbg
  );

  modport slave (
    input  traffic_jam_0, traffic_jam_1, traffic_jam_2, traffic_jam_3,
    input  allow_0_jam, allow_1_jam, allow_2_jam, allow_3_jam,
    output jam_opp_en, jam_start, jam_rotation, serve_lane, rotation_cnt,
    output ack_err, state_dbg
  );

endinterface

// File: rtl/jam_green_timer.sv
// jam_green_timer: loadable down-counter that times each green period.
//   clk, rst  clock, asynchronous active-high reset
//   load      load load_val this cycle (wins over en)
//   load_val  value loaded
//   en        decrement by one; holds at zero
//   zero      counter currently equals zero
module jam_green_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/jam_ctrl_unit.sv
// jam_ctrl_unit: jam-mode sequencer for the jam-opportunity arbiter.
// Debounces entry into jam mode, enables the arbiter, issues jam_start and
// jam_rotation pulses on a fixed green-time schedule and leaves jam mode
// when no lane is jammed at a rotation point.
//   clk, rst  clock, asynchronous active-high reset
//   bus       jam_ctrl_unit_if.slave (lane flags, grant feedback, controls)
// Parameters: DEBOUNCE_CYCLES (1..255), GREEN_CYCLES (2..255), CNT_W.
// Build option: define JAM_CTRL_ACK_CHECK_EN to build the sticky
// grant-acknowledge check on ack_err; otherwise ack_err is tied low.
module jam_ctrl_unit
  import jam_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GREEN_CYCLES    = DEF_GREEN_CYCLES,
  parameter int CNT_W           = 8
) (
  input  logic          clk,
  input  logic          rst,
  jam_ctrl_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] GREEN_LOAD = CNT_W'(GREEN_CYCLES - 1);

  logic       any_jam;
  logic [3:0] allow_v;

  jam_state_e       state_q, state_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic             start_q, start_d;
  logic             rot_q, rot_d;
  logic             en_q, en_d;
  lane_idx_t        lane_q, lane_d;
  logic [7:0]       rcnt_q, rcnt_d;

  logic timer_load, timer_en, timer_zero;

  assign any_jam = bus.traffic_jam_0 | bus.traffic_jam_1 |
                   bus.traffic_jam_2 | bus.traffic_jam_3;
  assign allow_v = {bus.allow_3_jam, bus.allow_2_jam,
                    bus.allow_1_jam, bus.allow_0_jam};

  // The timer is loaded during the single START/ROTATE cycle so the first
  // SERVE cycle holds GREEN_CYCLES-1 and the zero edge ends exactly
  // GREEN_CYCLES SERVE cycles later.
  assign timer_load = (state_q == ST_START) || (state_q == ST_ROTATE);
  assign timer_en   = (state_q == ST_SERVE);

  jam_green_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (GREEN_LOAD),
    .en       (timer_en),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d = state_q;
    deb_d   = '0;
    rcnt_d  = rcnt_q;
    lane_d  = lane_encode(allow_v);

    case (state_q)
      ST_IDLE: begin
        if (any_jam) begin
          if ((deb_q + CNT_W'(1)) == DEB_LAST) state_d = ST_START;
          else                                 deb_d   = deb_q + CNT_W'(1);
        end
      end
      ST_START:  state_d = ST_SERVE;
      ST_SERVE: begin
        // Green time always runs to completion; the jam flags only matter
        // at expiry.
        if (timer_zero) state_d = any_jam ? ST_ROTATE : ST_IDLE;
      end
      ST_ROTATE: state_d = ST_SERVE;
      default:   state_d = ST_IDLE;
    endcase

    if (state_d == ST_START) begin
      rcnt_d = '0;
    end else if ((state_d == ST_ROTATE) && (rcnt_q != 8'hFF)) begin
      rcnt_d = rcnt_q + 8'd1;
    end

    // Outputs are decoded from the next state so they register alongside it.
    start_d = (state_d == ST_START);
    rot_d   = (state_d == ST_ROTATE);
    en_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      deb_q   <= '0;
      start_q <= 1'b0;
      rot_q   <= 1'b0;
      en_q    <= 1'b0;
      lane_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      start_q <= start_d;
      rot_q   <= rot_d;
      en_q    <= en_d;
      lane_q  <= lane_d;
      rcnt_q  <= rcnt_d;
    end
  end

`ifdef JAM_CTRL_ACK_CHECK_EN
  // first_q marks the first SERVE cycle after START/ROTATE, which is the
  // cycle in which the arbiter's fresh grant must be exactly one-hot.
  logic first_q, first_d;
  logic ack_q, ack_d;

  always_comb begin
    first_d = (state_q == ST_START) || (state_q == ST_ROTATE);
    ack_d   = ack_q | (first_q && !is_onehot(allow_v));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      first_q <= first_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.ack_err = ack_q;
`else
  assign bus.ack_err = 1'b0;
`endif

  assign bus.jam_opp_en   = en_q;
  assign bus.jam_start    = start_q;
  assign bus.jam_rotation = rot_q;
  assign bus.serve_lane   = lane_q;
  assign bus.rotation_cnt = rcnt_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_jam_ctrl_unit.sv
// tb_jam_ctrl_unit: directed plus randomized checks of jam_ctrl_unit with a
// behavioural arbiter and a cycle-position reference model.
module tb_jam_ctrl_unit;

  localparam int D = 4;
  localparam int G = 20;
`ifdef JAM_CTRL_ACK_CHECK_EN
  localparam bit ACK_ON = 1'b1;
`else
  localparam bit ACK_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jam_ctrl_unit_if bus();

  jam_ctrl_unit #(.DEBOUNCE_CYCLES(D), .GREEN_CYCLES(G), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // stimulus and arbiter state
  logic [3:0] tj = 4'h0;
  logic [3:0] g  = 4'h0;
  bit         force0 = 1'b0;
  int         cyc = 0;

  // reference model: m_pos is cycles since the last START/ROTATE cycle
  bit m_active, m_isrot, m_ack;
  int m_pos, m_run, m_rot, m_lane;

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string pfx);
    chk({pfx, ":jam_opp_en"},   32'(bus.jam_opp_en),   32'(m_active));
    chk({pfx, ":jam_start"},    32'(bus.jam_start),    32'(m_active && m_pos == 0 && !m_isrot));
    chk({pfx, ":jam_rotation"}, 32'(bus.jam_rotation), 32'(m_active && m_pos == 0 && m_isrot));
    chk({pfx, ":rotation_cnt"}, 32'(bus.rotation_cnt), 32'(m_rot));
    chk({pfx, ":serve_lane"},   32'(bus.serve_lane),   32'(m_lane));
    chk({pfx, ":ack_err"},      32'(bus.ack_err),      32'(m_ack));
  endtask

  // ---------------- models ----------------
  task automatic model_reset();
    m_active = 0; m_isrot = 0; m_ack = 0;
    m_pos = 0; m_run = 0; m_rot = 0; m_lane = 0;
  endtask

  // Advance the model across one rising edge given the pre-edge inputs.
  task automatic model_edge(input bit any, input logic [3:0] al);
    m_lane = 0;
    for (int i = 3; i >= 0; i--) if (al[i]) m_lane = i;
    if (!m_active) begin
      m_run = any ? m_run + 1 : 0;
      if (m_run == D) begin
        m_active = 1; m_pos = 0; m_isrot = 0; m_rot = 0; m_run = 0;
      end
    end else if (m_pos < G) begin
      if (m_pos == 1 && ACK_ON && $countones(al) != 1) m_ack = 1;
      m_pos++;
    end else if (any) begin
      m_pos = 0; m_isrot = 1;
      if (m_rot < 255) m_rot++;
    end else begin
      m_active = 0; m_run = 0;
    end
  endtask

  // Arbiter: initial pick is the lowest jammed lane; rotation moves to the
  // next jammed lane round-robin; grants clear while the enable is low.
  function automatic logic [3:0] arb_next(input bit en, input bit st, input bit rt,
                                          input logic [3:0] flags, input logic [3:0] cur_g,
                                          input bit zero_out);
    logic [3:0] r;
    int cur;
    r = 4'h0;
    if (zero_out || !en) return r;
    if (st) begin
      for (int i = 0; i < 4; i++) if (flags[i]) begin r[i] = 1'b1; return r; end
      return r;
    end
    if (rt) begin
      cur = 3;
      for (int i = 0; i < 4; i++) if (cur_g[i]) cur = i;
      for (int k = 1; k <= 4; k++) if (flags[(cur + k) % 4]) begin
        r[(cur + k) % 4] = 1'b1;
        return r;
      end
      return r;
    end
    return cur_g;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive();
    bus.traffic_jam_0 = tj[0]; bus.traffic_jam_1 = tj[1];
    bus.traffic_jam_2 = tj[2]; bus.traffic_jam_3 = tj[3];
    bus.allow_0_jam = g[0]; bus.allow_1_jam = g[1];
    bus.allow_2_jam = g[2]; bus.allow_3_jam = g[3];
  endtask

  task automatic tick();
    bit o_en, o_st, o_rt;
    logic [3:0] tj_pre, g_pre;
    drive();
    o_en = bus.jam_opp_en; o_st = bus.jam_start; o_rt = bus.jam_rotation;
    tj_pre = tj; g_pre = g;
    @(posedge clk); #1;
    cyc++;
    model_edge(|tj_pre, g_pre);
    g = arb_next(o_en, o_st, o_rt, tj_pre, g_pre, force0);
    drive();
    compare_all("cyc");
  endtask

  // Reset asserted away from the clock edge; outputs must clear at once.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    g = 4'h0;
    drive();
    #1;
    model_reset();
    compare_all(tag);
    @(posedge clk); @(posedge clk); #1;
    compare_all({tag, "_held"});
    rst = 1'b0;
    cyc = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t_start, t_rot, n_rot, n_start, pat, len;
    drive();
    #2;
    apply_reset("reset");

    // idle with no jams: enable must stay low
    repeat (6) tick();
    chk("idle_no_enable", 32'(bus.jam_opp_en), 32'd0);

    // entry on lane 2
    tj = 4'b0100;
    t_start = -1; t_rot = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus.jam_start && t_start < 0) t_start = k;
      if (bus.jam_rotation && t_rot < 0) t_rot = k;
      if (t_start > 0 && k == t_start + 2) chk("entry_serve_lane", 32'(bus.serve_lane), 32'd2);
    end
    chk("entry_start_cycle", 32'(t_start), 32'(D));
    chk("entry_rotation_gap", 32'(t_rot - t_start), 32'(G + 1));
    chk("entry_rot_cnt", 32'(bus.rotation_cnt), 32'd1);

    // exit: jams drop mid-SERVE, green time still runs out
    tj = 4'h0;
    n_rot = 0;
    repeat (25) begin
      tick();
      if (bus.jam_rotation) n_rot++;
    end
    chk("exit_no_rotation", 32'(n_rot), 32'd0);
    chk("exit_enable_low", 32'(bus.jam_opp_en), 32'd0);
    chk("exit_rot_cnt_hold", 32'(bus.rotation_cnt), 32'd1);

    // debounce reject: three cycles is not enough
    tj = 4'b0001;
    n_start = 0;
    repeat (3) begin tick(); if (bus.jam_start) n_start++; end
    tj = 4'h0;
    repeat (2) begin tick(); if (bus.jam_start) n_start++; end
    chk("debounce_reject", 32'(n_start), 32'd0);
    tj = 4'b0001;
    t_start = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.jam_start && t_start < 0) t_start = k;
    end
    chk("debounce_fresh", 32'(t_start), 32'(D));

    // reset mid-SERVE, then a full debounce again
    repeat (5) tick();
    chk("pre_reset_serving", 32'(bus.jam_opp_en), 32'd1);
    apply_reset("rst_mid");
    tj = 4'b1000;
    t_start = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.jam_start && t_start < 0) t_start = k;
    end
    chk("reentry_debounce", 32'(t_start), 32'(D));

    // randomized lane traffic
    for (int s = 0; s < 25; s++) begin
      pat = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      len = $urandom_range(1, 30);
      tj = 4'(pat);
      repeat (len) tick();
    end

    // ack check: arbiter never grants
    tj = 4'h0;
    apply_reset("rst_ack");
    force0 = 1'b1;
    tj = 4'b0010;
    repeat (30) tick();
    force0 = 1'b0;
    repeat (25) tick();
    chk("ack_sticky", 32'(bus.ack_err), 32'(ACK_ON));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
